// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter timer with one-shot and auto-reload modes.
// Latency: register writes land at the clk edge; dout is combinational from addr; irq is registered.
// Backpressure: none -- single-cycle bus port, every access completes in the cycle it is presented.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset (0 = reset)
//   addr  - word select: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved (reads 0)
//   we    - write enable, sampled on rising clk
//   din   - write data
//   dout  - read data for the selected word
//   irq   - interrupt request (pending & CTRL.IM)
`timescale 1ns/1ps
module timer_counter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    addr,
  input  logic          we,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [DW-1:0] count, count_nxt;
  logic [DW-1:0] preset;
  logic          en, im;
  logic [1:0]    mode;
  logic          irq_pending;

  logic          ctrl_wr, preset_wr;
  logic          en_eff;
  logic          auto_eff;
  logic          set_pend;
  logic          hw_en_clr;

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);

  // The FSM sees a CTRL write in the same cycle it is presented, so enabling
  // from IDLE and disabling from CNT both act at the write edge itself.
  assign en_eff   = ctrl_wr ? din[0] : en;
  assign auto_eff = ctrl_wr ? (din[2:1] == 2'b01) : (mode == 2'b01);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    set_pend  = 1'b0;
    hw_en_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_eff) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en_eff) begin
          state_nxt = S_IDLE;
        end else if (count <= ONE) begin
          // PRESET=0 lands here too, so the counter never wraps.
          count_nxt = '0;
          state_nxt = S_INT;
        end else begin
          count_nxt = count - ONE;
        end
      end
      S_INT: begin
        set_pend = 1'b1;
        if (auto_eff) begin
          state_nxt = S_LOAD;
        end else begin
          hw_en_clr = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      preset <= '0;
    end else begin
      if (ctrl_wr) begin
        // Hardware EN clear at the end of a one-shot beats a simultaneous write.
        en   <= din[0] & ~hw_en_clr;
        mode <= din[2:1];
        im   <= din[3];
      end else if (hw_en_clr) begin
        en <= 1'b0;
      end
      if (preset_wr) preset <= din;
    end
  end

  // Set beats a same-cycle CTRL write; the LOAD clear turns auto-reload
  // interrupts into a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (set_pend) begin
      irq_pending <= 1'b1;
    end else if (ctrl_wr || (state == S_LOAD)) begin
      irq_pending <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {{(DW-4){1'b0}}, im, mode, en};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = '0;
    endcase
  end

  assign irq = irq_pending & im;

endmodule

// File: tb/tb_timer_counter.sv
`timescale 1ns/1ps
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check(dout, exp, tag);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = '0;

    // Reset state
    #2;
    check(32'(irq), 0, "rst_irq");
    rd(2'd0, 32'h0, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_preset");
    rd(2'd2, 32'h0, "rst_count");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Register map: CTRL upper bits ignored, addr 3 reads 0, COUNT read-only
    wr(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, 32'h0, "ctrl_upper_ignored");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0, "addr3_reads0");
    rd(2'd1, 32'h0, "addr3_no_side_effect");

    // 1. Asynchronous reset mid-count
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    rd(2'd2, 32'd7, "t1_count7");
    #1;
    reset = 1'b0;
    #1;
    check(32'(irq), 0, "t1_irq_async");
    rd(2'd0, 32'h0, "t1_ctrl_async");
    rd(2'd2, 32'h0, "t1_count_async");
    rd(2'd1, 32'h0, "t1_preset_async");
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    rd(2'd2, 32'h0, "t1_count_idle");
    rd(2'd0, 32'h0, "t1_ctrl_idle");
    check(32'(irq), 0, "t1_irq_idle");

    // 2. One-shot, PRESET=5: irq rises 7 edges after the CTRL write, sticky
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check(32'(irq), 0, $sformatf("t2_irq_low_%0d", k));
      rd(2'd2, 32'(6 - k), $sformatf("t2_count_%0d", k));
    end
    tick();
    check(32'(irq), 1, "t2_irq_rise");
    rd(2'd0, 32'h8, "t2_ctrl_en_cleared");
    tick();
    tick();
    check(32'(irq), 1, "t2_irq_sticky");
    rd(2'd2, 32'h0, "t2_count_held0");
    wr(2'd0, 32'h0);
    check(32'(irq), 0, "t2_irq_cleared");

    // 3. Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 21; e++) begin
      tick();
      check(32'(irq), ((e % 5) == 0) ? 32'd1 : 32'd0, $sformatf("t3_irq_e%0d", e));
      if ((e % 5) == 1) rd(2'd2, 32'd3, $sformatf("t3_reload_e%0d", e));
    end
    wr(2'd0, 32'h0);

    // 4. Disable freezes COUNT; re-enable reloads PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    rd(2'd2, 32'd6, "t4_count6");
    wr(2'd0, 32'h0);
    tick();
    tick();
    tick();
    rd(2'd2, 32'd6, "t4_frozen");
    check(32'(irq), 0, "t4_no_irq");
    wr(2'd0, 32'h1);
    rd(2'd2, 32'd6, "t4_load_cycle");
    tick();
    rd(2'd2, 32'd10, "t4_reloaded");
    wr(2'd0, 32'h0);

    // 5a. PRESET=0 one-shot, IM=0; a later CTRL write clears pending
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    tick();
    tick();
    tick();
    check(32'(irq), 0, "t5_masked");
    rd(2'd0, 32'h0, "t5_en_cleared");
    wr(2'd0, 32'h8);
    check(32'(irq), 0, "t5_write_clears_pending");
    rd(2'd0, 32'h8, "t5_ctrl_im");
    tick();
    check(32'(irq), 0, "t5_still_low");

    // 5b. IM set before INT exposes the interrupt
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h9);
    tick();
    check(32'(irq), 0, "t5b_before_int");
    tick();
    check(32'(irq), 1, "t5b_irq");
    rd(2'd0, 32'h8, "t5b_ctrl");

    // 5c. CTRL write in the INT cycle: pending set wins, hardware EN clear wins
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h1);
    tick();
    tick();
    wr(2'd0, 32'h9);
    check(32'(irq), 1, "t5c_set_wins");
    rd(2'd0, 32'h8, "t5c_en_clear_wins");
    wr(2'd0, 32'h0);

    // MODE=2'b10 behaves as one-shot
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hD);
    tick();
    tick();
    tick();
    check(32'(irq), 1, "mode10_irq");
    rd(2'd0, 32'hC, "mode10_ctrl");
    tick();
    check(32'(irq), 1, "mode10_sticky");
    wr(2'd0, 32'h0);

    // 6. PRESET and COUNT writes during CNT
    wr(2'd1, 32'd8);
    wr(2'd0, 32'hB);
    tick();
    rd(2'd2, 32'd8, "t6_count8");
    wr(2'd1, 32'd2);
    wr(2'd2, 32'h55);
    rd(2'd2, 32'd6, "t6_count_write_ignored");
    rd(2'd1, 32'd2, "t6_preset2");
    for (int e = 4; e <= 14; e++) begin
      tick();
      check(32'(irq), ((e == 10) || (e == 14)) ? 32'd1 : 32'd0, $sformatf("t6_irq_e%0d", e));
      if (e <= 9) rd(2'd2, (e == 9) ? 32'd0 : 32'(9 - e), $sformatf("t6_count_e%0d", e));
      if (e == 11) rd(2'd2, 32'd2, "t6_reload2");
    end
    wr(2'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
